// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, state type and BCD helper for the seven-segment controller
package seg7_pkg;

    localparam logic [1:0] REG_VALUE  = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int CTRL_HEX     = 0;
    localparam int CTRL_LZB     = 1;
    localparam int CTRL_MASK_LO = 4;

    localparam logic [3:0] DIGIT_OFF = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_e;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 16-bit double-dabble converter, one bit per cycle
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        done,
    output logic [19:0] bcd
);

    // BCD digits and the remaining binary bits share one shift register: {bcd[19:0], bin[15:0]}
    logic [35:0] shift_q, shift_d;
    logic [35:0] adj;
    logic [3:0]  cnt_q, cnt_d;
    logic        active_q, active_d;

    always_comb begin
        adj = {add3(shift_q[35:32]), add3(shift_q[31:28]), add3(shift_q[27:24]),
               add3(shift_q[23:20]), add3(shift_q[19:16]), shift_q[15:0]};
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            shift_d  = {20'd0, bin};
            cnt_d    = 4'd0;
            active_d = 1'b1;
        end else if (active_q) begin
            shift_d = adj << 1;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    // High during the last shift cycle so the caller can leave SHIFT right on time
    assign done = active_q && (cnt_q == 4'd15);
    assign bcd  = shift_q[35:16];

endmodule

// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - bus registers, conversion FSM and digit composition for the 4-digit display
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter logic [15:0] RESET_DISP = 16'hFFFF
) (
    input  logic              clock_100Mhz,
    input  logic              reset,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [3:0]        addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [15:0]       displayed_number_o,
    output logic              busy_o
);

    state_e      state_q, state_d;
    logic [15:0] value_q, value_d;
    logic        hex_q, hex_d;
    logic        lzb_q, lzb_d;
    logic [3:0]  mask_q, mask_d;
    logic        overflow_q, overflow_d;
    logic [15:0] disp_q, disp_d;

    logic [1:0]  reg_sel;
    logic        busy;
    logic        wr_en, wr_value, wr_ctrl, start_conv, bcd_start, bcd_done;
    logic [19:0] bcd;
    logic [15:0] comp;
    logic        ovf;
    logic        unused_bits;

    assign reg_sel    = addr_i[3:2];
    assign busy       = (state_q != IDLE);
    assign ready_o    = req_i & ~(we_i & busy & ((reg_sel == REG_VALUE) | (reg_sel == REG_CTRL)));
    assign wr_en      = ready_o & we_i;
    assign wr_value   = wr_en & (reg_sel == REG_VALUE);
    assign wr_ctrl    = wr_en & (reg_sel == REG_CTRL);
    assign start_conv = wr_value | wr_ctrl;
    assign bcd_start  = start_conv & ~hex_d;
    assign unused_bits = ^{wdata_i[DATA_W-1:16], wdata_i[3:2], addr_i[1:0]};

    always_comb begin
        value_d = value_q;
        hex_d   = hex_q;
        lzb_d   = lzb_q;
        mask_d  = mask_q;
        if (wr_value) begin
            value_d = wdata_i[15:0];
        end
        if (wr_ctrl) begin
            hex_d  = wdata_i[CTRL_HEX];
            lzb_d  = wdata_i[CTRL_LZB];
            mask_d = wdata_i[CTRL_MASK_LO +: 4];
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clock_100Mhz),
        .reset (reset),
        .start (bcd_start),
        .bin   (value_d),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_conv) state_d = hex_d ? UPDATE : SHIFT;
            SHIFT:   if (bcd_done)   state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decimal digits never hold 4'hF, so an F above a zero means "already blanked"
    always_comb begin
        ovf  = ~hex_q & (bcd[19:16] != 4'd0);
        comp = hex_q ? value_q : bcd[15:0];
        if (!hex_q && lzb_q) begin
            if (comp[15:12] == 4'd0) comp[15:12] = DIGIT_OFF;
            if (comp[15:12] == DIGIT_OFF && comp[11:8] == 4'd0) comp[11:8] = DIGIT_OFF;
            if (comp[11:8] == DIGIT_OFF && comp[7:4] == 4'd0) comp[7:4] = DIGIT_OFF;
        end
        for (int i = 0; i < 4; i++) begin
            if (mask_q[i]) comp[i*4 +: 4] = DIGIT_OFF;
        end
        if (ovf) comp = {4{DIGIT_OFF}};
    end

    always_comb begin
        disp_d     = disp_q;
        overflow_d = overflow_q;
        if (state_q == UPDATE) begin
            disp_d     = comp;
            overflow_d = ovf;
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_q    <= IDLE;
            value_q    <= '0;
            hex_q      <= 1'b0;
            lzb_q      <= 1'b0;
            mask_q     <= '0;
            overflow_q <= 1'b0;
            disp_q     <= RESET_DISP;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            hex_q      <= hex_d;
            lzb_q      <= lzb_d;
            mask_q     <= mask_d;
            overflow_q <= overflow_d;
            disp_q     <= disp_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (reg_sel)
            REG_VALUE:  rdata_o[15:0] = value_q;
            REG_CTRL:   rdata_o[7:0]  = {mask_q, 2'b00, lzb_q, hex_q};
            REG_STATUS: rdata_o[1:0]  = {overflow_q, busy};
            REG_RSVD:   rdata_o       = '0;
            default:    rdata_o       = '0;
        endcase
    end

    assign displayed_number_o = disp_q;
    assign busy_o             = busy;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - scoreboard bench for seg7_display_ctrl
module tb_seg7_display_ctrl;

    localparam logic [3:0] A_VALUE  = 4'h0;
    localparam logic [3:0] A_CTRL   = 4'h4;
    localparam logic [3:0] A_STATUS = 4'h8;
    localparam logic [3:0] A_RSVD   = 4'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_i, we_i;
    logic [3:0]  addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic [31:0] rdata_o;
    logic [15:0] displayed_number_o;
    logic        busy_o;

    always #5 clk = ~clk;

    seg7_display_ctrl #(.DATA_W(32), .RESET_DISP(16'hFFFF)) dut (
        .clock_100Mhz       (clk),
        .reset              (reset),
        .req_i              (req_i),
        .we_i               (we_i),
        .addr_i             (addr_i),
        .wdata_i            (wdata_i),
        .ready_o            (ready_o),
        .rdata_o            (rdata_o),
        .displayed_number_o (displayed_number_o),
        .busy_o             (busy_o)
    );

    typedef struct {
        logic [15:0] val;
        int          at;
    } disp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic        prev_busy = 1'b0;
    disp_t       disp_q[$];
    logic [31:0] rd_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: read responses on accepted reads, display results when busy drops
    always @(negedge clk) begin : monitor
        logic [31:0] er;
        disp_t       ed;
        if (mon_en) begin
            if (req_i && ready_o && !we_i) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rdata_unexpected: got %h with no expected read", rdata_o);
                end else begin
                    er = rd_q.pop_front();
                    if (rdata_o !== er) begin
                        errors++;
                        $display("FAIL rdata addr=%h: got %h expected %h", addr_i, rdata_o, er);
                    end
                end
            end
            if (prev_busy === 1'b1 && busy_o === 1'b0) begin
                checks++;
                if (disp_q.size() == 0) begin
                    errors++;
                    $display("FAIL display_unexpected: got %h at cycle %0d", displayed_number_o, cyc);
                end else begin
                    ed = disp_q.pop_front();
                    if (displayed_number_o !== ed.val || cyc != ed.at) begin
                        errors++;
                        $display("FAIL display: got %h at cycle %0d expected %h at cycle %0d",
                                 displayed_number_o, cyc, ed.val, ed.at);
                    end
                end
            end
            prev_busy = busy_o;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp);
        req_i = 1'b1; we_i = 1'b0; addr_i = a;
        rd_q.push_back(exp);
        @(negedge clk);
        check("read_ready", {31'd0, ready_o}, 32'd1);
        @(posedge clk); #1;
        req_i = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input bit push,
                            input logic [15:0] exp, input bit hex, output int acc);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready_o) begin
                acc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL write_timeout addr=%h: ready_o %b expected 1", a, ready_o);
        end else if (push) begin
            disp_q.push_back('{exp, acc + (hex ? 2 : 18)});
        end
        @(posedge clk); #1;
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (seen) begin
            @(posedge clk); #1;
        end else begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy_o %b expected 0", busy_o);
        end
    endtask

    task automatic wr_conv(input logic [3:0] a, input logic [31:0] d,
                           input logic [15:0] exp, input bit hex);
        int acc;
        do_write(a, d, 1'b1, exp, hex, acc);
        check("busy_after_write", {31'd0, busy_o}, 32'd1);
        wait_idle();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int t0, c, acc;
        reset = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_display", {16'd0, displayed_number_o}, 32'h0000FFFF);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        mon_en = 1'b1;
        do_read(A_STATUS, 32'd0);

        wr_conv(A_VALUE, 32'd1234, 16'h1234, 1'b0);

        wr_conv(A_CTRL, 32'h02, 16'h1234, 1'b0);
        wr_conv(A_VALUE, 32'd42, 16'hFF42, 1'b0);
        wr_conv(A_VALUE, 32'd0, 16'hFFF0, 1'b0);
        wr_conv(A_VALUE, 32'd1000, 16'h1000, 1'b0);

        wr_conv(A_VALUE, 32'd10000, 16'hFFFF, 1'b0);
        do_read(A_STATUS, 32'h2);
        wr_conv(A_VALUE, 32'd9999, 16'h9999, 1'b0);
        do_read(A_STATUS, 32'h0);
        wr_conv(A_VALUE, 32'd10000, 16'hFFFF, 1'b0);
        do_read(A_STATUS, 32'h2);

        wr_conv(A_CTRL, 32'h11, 16'h271F, 1'b1);
        do_read(A_STATUS, 32'h0);
        wr_conv(A_VALUE, 32'h0000BEEF, 16'hBEEF, 1'b1);
        do_read(A_CTRL, 32'h11);
        do_read(A_VALUE, 32'h0000BEEF);
        wr_conv(A_CTRL, 32'h93, 16'hFEEF, 1'b1);
        wr_conv(A_VALUE, 32'h00000012, 16'hF01F, 1'b1);

        wr_conv(A_CTRL, 32'hFFFFFF2E, 16'hFFF8, 1'b0);
        do_read(A_CTRL, 32'h22);
        do_read(A_RSVD, 32'h0);

        do_write(A_VALUE, 32'd1234, 1'b1, 16'h12F4, 1'b0, t0);
        do_read(A_STATUS, 32'h1);
        do_read(A_STATUS, 32'h1);
        c = cyc;
        do_write(A_RSVD, 32'hFFFFFFFF, 1'b0, 16'h0, 1'b0, acc);
        check("rsvd_write_no_stall", acc, c);
        do_write(A_VALUE, 32'd5678, 1'b1, 16'h56F8, 1'b0, acc);
        check("stalled_write_accept_cycle", acc, t0 + 18);
        wait_idle();
        do_read(A_STATUS, 32'h0);
        do_read(A_VALUE, 32'd5678);

        do_write(A_VALUE, 32'd4321, 1'b0, 16'h0, 1'b0, acc);
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(negedge clk);
        disp_q.push_back('{16'hFFFF, cyc + 1});
        @(posedge clk); #1;
        reset = 1'b0;
        check("busy_after_reset", {31'd0, busy_o}, 32'd0);
        wait_idle();
        do_read(A_STATUS, 32'h0);
        do_read(A_CTRL, 32'h0);
        do_read(A_VALUE, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", rd_q.size() + disp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
